// File: rtl/pool2x2_mc.sv
// Multi-channel 2x2 stride-2 pooling engine (signed max / floored average).
// Streams a square map from pixel memory, one read per cycle, one write per window.
module pool2x2_mc #(
    parameter int SIZE             = 8,
    parameter int CH               = 4,
    parameter int SIZE_address_pix = 13
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        pool_en,
    input  logic                        mode,
    input  logic [9:0]                  matrix,
    input  logic [SIZE_address_pix-1:0] memstartp,
    input  logic [SIZE_address_pix-1:0] memstartzap,
    input  logic [SIZE*CH-1:0]          qp,
    output logic [SIZE_address_pix-1:0] read_addressp,
    output logic                        re,
    output logic [SIZE_address_pix-1:0] write_addressp,
    output logic [SIZE*CH-1:0]          dp,
    output logic                        we,
    output logic                        STOP
);

    localparam int AW = SIZE_address_pix;
    localparam int W  = SIZE * CH;
    localparam int AL = SIZE + 2;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t          r_state, w_state_n;
    logic            r_mode;
    logic [9:0]      r_m;
    logic [8:0]      r_o, r_ox, r_oy;
    logic [8:0]      w_ox_n, w_oy_n, w_o_in;
    logic [AW-1:0]   r_zap, r_b, r_row, r_n;
    logic [AW-1:0]   w_b_n, w_row_n;
    logic [AW-1:0]   r_addr, w_addr_n, r_waddr;
    logic [AW-1:0]   w_m, w_m2, w_off;
    logic [1:0]      r_el, w_el_n, r_rd_el, w_rd_el_n;
    logic            r_re, w_re_n, r_we, r_stop, w_stop_n;
    logic            w_start, w_fire, w_last_win;
    logic [W-1:0]    r_dp, w_res;
    logic [AL*CH-1:0] r_acc, w_acc_n;

    assign w_o_in     = matrix[9:1];
    assign w_m        = AW'(r_m);
    assign w_m2       = AW'({r_m, 1'b0});
    assign w_last_win = (r_ox == r_o - 9'd1) && (r_oy == r_o - 9'd1);
    assign w_fire     = r_re && pool_en && (r_rd_el == 2'd3);

    always_comb begin
        unique case (r_el)
            2'd0:    w_off = '0;
            2'd1:    w_off = AW'(1);
            2'd2:    w_off = w_m;
            default: w_off = w_m + AW'(1);
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_n;
    end

    always_comb begin
        w_state_n = r_state;
        if (!pool_en) begin
            w_state_n = IDLE;
        end else begin
            unique case (r_state)
                IDLE:  w_state_n = (w_o_in == '0) ? DONE : RUN;
                RUN:   if (r_el == 2'd3 && w_last_win) w_state_n = DRAIN;
                DRAIN: w_state_n = DONE;
                DONE:  w_state_n = DONE;
                default: w_state_n = IDLE;
            endcase
        end
    end

    // Read-side next values; counters point at the next read to issue.
    always_comb begin
        w_re_n    = 1'b0;
        w_addr_n  = r_addr;
        w_el_n    = r_el;
        w_rd_el_n = r_rd_el;
        w_b_n     = r_b;
        w_row_n   = r_row;
        w_ox_n    = r_ox;
        w_oy_n    = r_oy;
        w_stop_n  = 1'b0;
        w_start   = 1'b0;
        if (pool_en) begin
            unique case (r_state)
                IDLE: begin
                    w_start   = 1'b1;
                    w_b_n     = memstartp;
                    w_row_n   = memstartp;
                    w_ox_n    = '0;
                    w_oy_n    = '0;
                    w_el_n    = 2'd0;
                    w_rd_el_n = 2'd0;
                    if (w_o_in != '0) begin
                        w_re_n   = 1'b1;
                        w_addr_n = memstartp;
                        w_el_n   = 2'd1;
                    end
                end
                RUN: begin
                    w_re_n    = 1'b1;
                    w_addr_n  = r_b + w_off;
                    w_el_n    = r_el + 2'd1;
                    w_rd_el_n = r_el;
                    if (r_el == 2'd3) begin
                        if (r_ox == r_o - 9'd1) begin
                            w_ox_n  = '0;
                            w_oy_n  = r_oy + 9'd1;
                            w_row_n = r_row + w_m2;
                            w_b_n   = r_row + w_m2;
                        end else begin
                            w_ox_n = r_ox + 9'd1;
                            w_b_n  = r_b + AW'(2);
                        end
                    end
                end
                DONE:    w_stop_n = 1'b1;
                default: w_stop_n = 1'b0;
            endcase
        end else begin
            w_el_n = 2'd0;
        end
    end

    // Element 0 reloads the lane accumulator so windows never mix.
    for (genvar g = 0; g < CH; g++) begin : g_lane
        logic signed [AL-1:0] w_q, w_a, w_n, w_sh;
        assign w_q  = AL'($signed(qp[g*SIZE +: SIZE]));
        assign w_a  = $signed(r_acc[g*AL +: AL]);
        assign w_n  = (r_rd_el == 2'd0) ? w_q :
                      r_mode ? (w_a + w_q) :
                      ((w_q > w_a) ? w_q : w_a);
        assign w_sh = w_n >>> 2;
        assign w_acc_n[g*AL +: AL] = w_n;
        assign w_res[g*SIZE +: SIZE] =
            r_mode ? w_sh[SIZE-1:0] : w_n[SIZE-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_re    <= 1'b0;
            r_addr  <= '0;
            r_el    <= '0;
            r_rd_el <= '0;
            r_b     <= '0;
            r_row   <= '0;
            r_ox    <= '0;
            r_oy    <= '0;
            r_stop  <= 1'b0;
            r_we    <= 1'b0;
            r_mode  <= 1'b0;
            r_m     <= '0;
            r_o     <= '0;
            r_zap   <= '0;
            r_n     <= '0;
            r_acc   <= '0;
            r_dp    <= '0;
            r_waddr <= '0;
        end else begin
            r_re    <= w_re_n;
            r_addr  <= w_addr_n;
            r_el    <= w_el_n;
            r_rd_el <= w_rd_el_n;
            r_b     <= w_b_n;
            r_row   <= w_row_n;
            r_ox    <= w_ox_n;
            r_oy    <= w_oy_n;
            r_stop  <= w_stop_n;
            r_we    <= w_fire;
            if (w_start) begin
                r_mode <= mode;
                r_m    <= matrix;
                r_o    <= w_o_in;
                r_zap  <= memstartzap;
                r_n    <= '0;
            end
            if (r_re) r_acc <= w_acc_n;
            if (w_fire) begin
                r_dp    <= w_res;
                r_waddr <= r_zap + r_n;
                r_n     <= r_n + AW'(1);
            end
        end
    end

    assign read_addressp  = r_addr;
    assign re             = r_re;
    assign write_addressp = r_waddr;
    assign dp             = r_dp;
    assign we             = r_we;
    assign STOP           = r_stop;

endmodule

// File: tb/tb_pool2x2_mc.sv
// Directed bench for pool2x2_mc: max/avg modes, lanes, odd maps,
// abort, mid-job reset and the empty-map case.
module tb_pool2x2_mc;

    localparam int SIZE = 8;
    localparam int CH   = 4;
    localparam int AW   = 13;
    localparam int W    = SIZE * CH;

    logic          clk = 0;
    logic          rst_n = 0;
    logic          pool_en = 0;
    logic          mode = 0;
    logic [9:0]    matrix = '0;
    logic [AW-1:0] memstartp = '0;
    logic [AW-1:0] memstartzap = '0;
    logic [W-1:0]  qp;
    logic [AW-1:0] read_addressp;
    logic          re;
    logic [AW-1:0] write_addressp;
    logic [W-1:0]  dp;
    logic          we;
    logic          STOP;

    pool2x2_mc #(.SIZE(SIZE), .CH(CH), .SIZE_address_pix(AW)) dut (
        .clk(clk), .rst_n(rst_n), .pool_en(pool_en), .mode(mode),
        .matrix(matrix), .memstartp(memstartp),
        .memstartzap(memstartzap), .qp(qp),
        .read_addressp(read_addressp), .re(re),
        .write_addressp(write_addressp), .dp(dp), .we(we), .STOP(STOP)
    );

    always #5 clk = ~clk;

    logic [W-1:0] mem [0:(1<<AW)-1];
    assign qp = re ? mem[read_addressp] : '0;

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [AW-1:0] rd_a[$];
    logic [AW-1:0] wr_a[$];
    logic [W-1:0]  wr_d[$];
    int first_we, stop_t, rd_first, rd_last, overlap;

    task automatic clear_mem();
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    endtask

    // Starts a job and samples every cycle; t is the index of the last edge.
    task automatic run_job(input logic [9:0] m, input logic md,
                           input logic [AW-1:0] ps,
                           input logic [AW-1:0] pz,
                           input int stop_at);
        rd_a.delete(); wr_a.delete(); wr_d.delete();
        first_we = -1; stop_t = -1;
        rd_first = -1; rd_last = -1; overlap = 0;
        matrix = m; mode = md; memstartp = ps; memstartzap = pz;
        @(negedge clk);
        pool_en = 1;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (re) begin
                rd_a.push_back(read_addressp);
                if (rd_first < 0) rd_first = t;
                rd_last = t;
            end
            if (we) begin
                wr_a.push_back(write_addressp);
                wr_d.push_back(dp);
                if (first_we < 0) first_we = t;
            end
            if (STOP && we) overlap = 1;
            if (t == stop_at) break;
            if (STOP) begin
                stop_t = t;
                break;
            end
        end
    endtask

    task automatic end_job();
        pool_en = 0;
        @(negedge clk);
        check("stop_clear", STOP, 0);
    endtask

    task automatic check_wr(input string tag, input int i,
                            input logic [AW-1:0] a,
                            input logic [W-1:0] d);
        if (i < wr_d.size()) begin
            check({tag, "_addr"}, wr_a[i], a);
            check({tag, "_data"}, wr_d[i], d);
        end else begin
            check({tag, "_missing"}, 0, 1);
        end
    endtask

    task automatic load_ramp(input logic [AW-1:0] base, input int n);
        for (int i = 0; i < n; i++) mem[base + AW'(i)] = W'(i);
    endtask

    int bad;

    initial begin
        clear_mem();
        repeat (3) @(negedge clk);
        check("rst_re", re, 0);
        check("rst_we", we, 0);
        check("rst_stop", STOP, 0);
        check("rst_raddr", read_addressp, 0);
        check("rst_waddr", write_addressp, 0);
        check("rst_dp", dp, 0);
        rst_n = 1;
        @(negedge clk);

        // Max, matrix=4, ramp 0..15
        load_ramp(0, 16);
        run_job(10'd4, 1'b0, 13'd0, 13'd100, -1);
        check("m4_nwr", wr_d.size(), 4);
        check_wr("m4_w0", 0, 13'd100, 32'd5);
        check_wr("m4_w1", 1, 13'd101, 32'd7);
        check_wr("m4_w2", 2, 13'd102, 32'd13);
        check_wr("m4_w3", 3, 13'd103, 32'd15);
        check("m4_first_we", first_we, 4);
        check("m4_stop_t", stop_t, 17);
        check("m4_nrd", rd_a.size(), 16);
        check("m4_rd_first", rd_first, 0);
        check("m4_rd_last", rd_last, 15);
        check("m4_overlap", overlap, 0);
        if (rd_a.size() >= 5) begin
            check("m4_rd2", rd_a[2], 13'd4);
            check("m4_rd3", rd_a[3], 13'd5);
            check("m4_rd4", rd_a[4], 13'd2);
        end
        end_job();

        // Average, matrix=2, floor for negatives plus lane extremes
        clear_mem();
        mem[200] = {8'sd127, -8'sd128, 8'sd1, -8'sd1};
        mem[201] = {8'sd127, -8'sd128, 8'sd2, -8'sd2};
        mem[202] = {8'sd127, -8'sd128, 8'sd3, -8'sd3};
        mem[203] = {8'sd127, -8'sd128, 8'sd5, -8'sd4};
        run_job(10'd2, 1'b1, 13'd200, 13'd300, -1);
        check("avg_nwr", wr_d.size(), 1);
        check_wr("avg_w0", 0, 13'd300, 32'h7F80_02FD);
        check("avg_stop_t", stop_t, 5);
        check("avg_first_we", first_we, 4);
        end_job();

        // Max across 4 lanes, permuted extremes per element
        clear_mem();
        mem[400] = 32'h00FF7F80; mem[401] = 32'h8000FF7F;
        mem[404] = 32'h7F8000FF; mem[405] = 32'hFF7F8000;
        mem[402] = 32'h80FF80FF; mem[403] = 32'h8080FF00;
        mem[406] = 32'h80FF0080; mem[407] = 32'hFF008080;
        mem[410] = 32'h80808080; mem[411] = 32'h80808080;
        mem[414] = 32'h80808080; mem[415] = 32'h80808080;
        run_job(10'd4, 1'b0, 13'd400, 13'd500, -1);
        check("ch4_nwr", wr_d.size(), 4);
        check_wr("ch4_w0", 0, 13'd500, 32'h7F7F7F7F);
        check_wr("ch4_w1", 1, 13'd501, 32'hFF000000);
        check_wr("ch4_w2", 2, 13'd502, 32'h00000000);
        check_wr("ch4_w3", 3, 13'd503, 32'h80808080);
        end_job();

        // Odd map, matrix=5: last row/column never read
        clear_mem();
        load_ramp(13'd1000, 25);
        run_job(10'd5, 1'b0, 13'd1000, 13'd2000, -1);
        check("odd_nrd", rd_a.size(), 16);
        check("odd_nwr", wr_d.size(), 4);
        bad = 0;
        foreach (rd_a[i]) begin
            if (rd_a[i] == 13'd1004 || rd_a[i] == 13'd1009 ||
                rd_a[i] == 13'd1014 ||
                (rd_a[i] >= 13'd1020 && rd_a[i] <= 13'd1024))
                bad++;
        end
        check("odd_forbidden", bad, 0);
        check_wr("odd_w0", 0, 13'd2000, 32'd6);
        check_wr("odd_w1", 1, 13'd2001, 32'd8);
        check_wr("odd_w2", 2, 13'd2002, 32'd16);
        check_wr("odd_w3", 3, 13'd2003, 32'd18);
        check("odd_stop_t", stop_t, 17);
        end_job();

        // Abort after 6 reads, then restart from output 0
        clear_mem();
        load_ramp(0, 16);
        run_job(10'd4, 1'b0, 13'd0, 13'd100, 5);
        check("abt_nrd", rd_a.size(), 6);
        pool_en = 0;
        @(negedge clk);
        check("abt_re", re, 0);
        check("abt_we", we, 0);
        check("abt_stop", STOP, 0);
        run_job(10'd4, 1'b0, 13'd0, 13'd100, -1);
        check("rst_first_rd", rd_a.size() > 0 ? rd_a[0] : 13'h1FFF, 0);
        check_wr("re_w0", 0, 13'd100, 32'd5);
        check_wr("re_w3", 3, 13'd103, 32'd15);
        check("re_stop_t", stop_t, 17);
        end_job();

        // Reset mid-job clears every output
        run_job(10'd4, 1'b0, 13'd0, 13'd100, 5);
        rst_n = 0;
        @(negedge clk);
        check("mrst_re", re, 0);
        check("mrst_we", we, 0);
        check("mrst_stop", STOP, 0);
        check("mrst_raddr", read_addressp, 0);
        check("mrst_waddr", write_addressp, 0);
        check("mrst_dp", dp, 0);
        pool_en = 0;
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);

        // Empty output map
        run_job(10'd1, 1'b0, 13'd0, 13'd100, -1);
        check("m1_stop_t", stop_t, 1);
        check("m1_nrd", rd_a.size(), 0);
        check("m1_nwr", wr_d.size(), 0);
        repeat (3) @(negedge clk);
        check("m1_stop_hold", STOP, 1);
        end_job();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
